// File: rtl/dmem_sram_responder.sv
// dmem_sram_responder: fixed-latency SRAM responder for the CPU data-memory port.
//   clk                 rising-edge clock
//   rst                 asynchronous reset, active-low
//   dmem_read/write     request strobes, held until dmem_resp
//   dmem_byte_enable    write lane mask (bit i -> wdata[8i+7:8i])
//   dmem_address        byte address, bits [1:0] ignored
//   dmem_wdata          write data
//   dmem_resp           one-cycle completion pulse, LATENCY cycles after acceptance
//   dmem_rdata          registered read data, held until the next response
//   oob_flag            sticky: an access fell outside the SRAM window
//   conflict_flag       sticky: read and write were requested together
module dmem_sram_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_resp,
    output logic [31:0] dmem_rdata,
    output logic        oob_flag,
    output logic        conflict_flag
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_sram_responder: LATENCY must be in 1..15");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
        $error("dmem_sram_responder: BASE_ADDR must be 4-byte aligned");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    q_write;
    logic                    q_oob;
    logic [ADDR_WIDTH-1:0]   q_idx;
    logic [3:0]              q_be;
    logic [31:0]             q_wdata;
    logic [31:0]             mem [DEPTH];

    logic                    req;
    logic [29:0]             word_off;
    logic                    req_oob;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic                    go_resp;
    logic                    a_write;
    logic                    a_oob;
    logic [ADDR_WIDTH-1:0]   a_idx;
    logic [3:0]              a_be;
    logic [31:0]             a_wdata;
    logic [31:0]             a_rdata;

    // Unsigned wrap of the subtraction makes addresses below BASE_ADDR land far out of range.
    assign req      = dmem_read | dmem_write;
    assign word_off = 30'((dmem_address - BASE_ADDR) >> 2);
    assign req_oob  = (word_off >> ADDR_WIDTH) != '0;
    assign req_idx  = word_off[ADDR_WIDTH-1:0];

    // The access is performed on the edge that enters RESP so that dmem_rdata is
    // registered and valid in the RESP cycle. With LATENCY=1 that edge is the
    // accepting edge, so the live request is used instead of the latched copy.
    assign go_resp = (state == IDLE && req && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
    assign a_write = (state == IDLE) ? dmem_write       : q_write;
    assign a_oob   = (state == IDLE) ? req_oob          : q_oob;
    assign a_idx   = (state == IDLE) ? req_idx          : q_idx;
    assign a_be    = (state == IDLE) ? dmem_byte_enable : q_be;
    assign a_wdata = (state == IDLE) ? dmem_wdata       : q_wdata;
    assign a_rdata = (a_write || a_oob) ? 32'h0 : mem[a_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            q_write       <= 1'b0;
            q_oob         <= 1'b0;
            q_idx         <= '0;
            q_be          <= '0;
            q_wdata       <= '0;
            dmem_resp     <= 1'b0;
            dmem_rdata    <= '0;
            oob_flag      <= 1'b0;
            conflict_flag <= 1'b0;
        end else begin
            dmem_resp <= go_resp;
            if (go_resp) begin
                dmem_rdata <= a_rdata;
                oob_flag   <= oob_flag | a_oob;
            end
            case (state)
                IDLE: if (req) begin
                    q_write       <= dmem_write;
                    q_oob         <= req_oob;
                    q_idx         <= req_idx;
                    q_be          <= dmem_byte_enable;
                    q_wdata       <= dmem_wdata;
                    conflict_flag <= conflict_flag | (dmem_read & dmem_write);
                    cnt           <= 4'(LATENCY - 1);
                    state         <= (LATENCY == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    cnt   <= cnt - 4'd1;
                    state <= (cnt == 4'd1) ? RESP : WAIT;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory has no reset; rst gating drops any write that would coincide with reset.
    always_ff @(posedge clk) begin
        if (rst && go_resp && a_write && !a_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_sram_responder.sv
// tb_dmem_sram_responder: vector table, corner sequences and random traffic against a reference model.
module tb_dmem_sram_responder;
    logic        clk;
    logic [1:0]  rst_n, rd, wr, resp, oob, conf;
    logic [3:0]  be    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];

    int nvec = 0;
    int nfail = 0;
    logic [31:0] mdl [int];
    bit exp_oob [2];
    bit exp_conf [2];

    typedef struct {
        int          d;
        bit          w;
        bit          r;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [$];

    dmem_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_a (
        .clk(clk), .rst(rst_n[0]), .dmem_read(rd[0]), .dmem_write(wr[0]),
        .dmem_byte_enable(be[0]), .dmem_address(addr[0]), .dmem_wdata(wd[0]),
        .dmem_resp(resp[0]), .dmem_rdata(rdata[0]), .oob_flag(oob[0]), .conflict_flag(conf[0]));

    dmem_sram_responder #(.ADDR_WIDTH(6), .LATENCY(1), .BASE_ADDR(32'h0000_1000)) u_b (
        .clk(clk), .rst(rst_n[1]), .dmem_read(rd[1]), .dmem_write(wr[1]),
        .dmem_byte_enable(be[1]), .dmem_address(addr[1]), .dmem_wdata(wd[1]),
        .dmem_resp(resp[1]), .dmem_rdata(rdata[1]), .oob_flag(oob[1]), .conflict_flag(conf[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    function automatic logic [31:0] base_of(input int d);
        return (d == 1) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction
    function automatic int words_of(input int d);
        return (d == 1) ? 64 : 1024;
    endfunction
    function automatic int lat_of(input int d);
        return (d == 1) ? 1 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One complete transaction; measures latency and pulse width, and keeps the model in step.
    task automatic access(input int d, input bit w, input bit r, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] dat, input bit scr,
                          output logic [31:0] rd_v, output logic [31:0] mexp, output bit known);
        int lat;
        bit got;
        int key;
        bit inr;
        logic [31:0] off;
        logic [31:0] cur;
        off   = a - base_of(d);
        inr   = off < 32'(4 * words_of(d));
        key   = d * (1 << 20) + int'(off[21:2]);
        known = 1'b1;
        mexp  = 32'h0;
        if (!w && inr) begin
            if (mdl.exists(key)) mexp = mdl[key];
            else known = 1'b0;
        end
        @(negedge clk);
        wr[d] = w; rd[d] = r; addr[d] = a; be[d] = b; wd[d] = dat;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (resp[d]) got = 1'b1;
            else if (scr) begin
                addr[d] = $urandom;
                wd[d]   = $urandom;
                be[d]   = 4'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    rd[d] = 1'b0;
                    wr[d] = 1'b0;
                end
            end
        end
        rd_v = rdata[d];
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        chk($sformatf("latency_d%0d", d), lat, lat_of(d));
        if (got) begin
            @(posedge clk);
            #1;
            chk($sformatf("resp_width_d%0d", d), {31'h0, resp[d]}, 32'h0);
        end
        if (w && inr) begin
            if (mdl.exists(key)) begin
                cur = mdl[key];
                for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = dat[8*i +: 8];
                mdl[key] = cur;
            end else if (b == 4'hF) mdl[key] = dat;
        end
        if (!inr) exp_oob[d] = 1'b1;
        if (w && r) exp_conf[d] = 1'b1;
    endtask

    initial begin
        logic [31:0] got_rd, mexp;
        bit known;
        int cnt;
        bit w, r;
        logic [31:0] a;

        rst_n = 2'b00;
        rd = 2'b00;
        wr = 2'b00;
        for (int d = 0; d < 2; d++) begin
            be[d] = 4'h0; addr[d] = 32'h0; wd[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_resp_d%0d", d), {31'h0, resp[d]}, 32'h0);
            chk($sformatf("reset_rdata_d%0d", d), rdata[d], 32'h0);
            chk($sformatf("reset_oob_d%0d", d), {31'h0, oob[d]}, 32'h0);
            chk($sformatf("reset_conflict_d%0d", d), {31'h0, conf[d]}, 32'h0);
        end
        @(negedge clk);
        rst_n = 2'b11;
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (resp != 2'b00) cnt++;
        end
        chk("idle_no_resp", cnt, 0);

        vt.push_back('{0, 1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF, 32'h0});
        vt.push_back('{0, 1'b0, 1'b1, 32'h0000_0040, 4'h0, 32'h0,         32'hDEAD_BEEF});
        vt.push_back('{0, 1'b1, 1'b0, 32'h0000_0040, 4'h5, 32'h1122_3344, 32'h0});
        vt.push_back('{0, 1'b0, 1'b1, 32'h0000_0042, 4'h0, 32'h0,         32'hDE22_BE44});
        vt.push_back('{0, 1'b1, 1'b0, 32'h0000_0044, 4'hF, 32'h0102_0304, 32'h0});
        vt.push_back('{0, 1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'hFFFF_FFFF, 32'h0});
        vt.push_back('{0, 1'b0, 1'b1, 32'h0000_0044, 4'h0, 32'h0,         32'h0102_0304});
        vt.push_back('{0, 1'b1, 1'b1, 32'h0000_0080, 4'hF, 32'hAABB_CCDD, 32'h0});
        vt.push_back('{0, 1'b0, 1'b1, 32'h0000_0080, 4'h0, 32'h0,         32'hAABB_CCDD});
        vt.push_back('{1, 1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'hCAFE_F00D, 32'h0});
        vt.push_back('{1, 1'b1, 1'b0, 32'h0000_10FC, 4'hF, 32'h1234_5678, 32'h0});
        vt.push_back('{1, 1'b0, 1'b1, 32'h0000_0FFC, 4'h0, 32'h0,         32'h0});
        vt.push_back('{1, 1'b0, 1'b1, 32'h0000_1100, 4'h0, 32'h0,         32'h0});
        vt.push_back('{1, 1'b1, 1'b0, 32'h0000_0FFC, 4'hF, 32'hBAD0_BAD0, 32'h0});
        vt.push_back('{1, 1'b1, 1'b0, 32'h0000_1100, 4'hF, 32'hBAD0_BAD0, 32'h0});
        vt.push_back('{1, 1'b0, 1'b1, 32'h0000_1000, 4'h0, 32'h0,         32'hCAFE_F00D});
        vt.push_back('{1, 1'b0, 1'b1, 32'h0000_10FC, 4'h0, 32'h0,         32'h1234_5678});
        foreach (vt[i]) begin
            access(vt[i].d, vt[i].w, vt[i].r, vt[i].a, vt[i].b, vt[i].dat, 1'b0, got_rd, mexp, known);
            chk($sformatf("vec%0d_rdata", i), got_rd, vt[i].exp);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rdata_hold_d1", rdata[1], 32'h1234_5678);
        chk("oob_flag_d0", {31'h0, oob[0]}, 32'h0);
        chk("oob_flag_d1", {31'h0, oob[1]}, 32'h1);
        chk("conflict_flag_d0", {31'h0, conf[0]}, 32'h1);
        chk("conflict_flag_d1", {31'h0, conf[1]}, 32'h0);

        // Reset during WAIT of a write: no response and the word keeps its old value.
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'h40; be[0] = 4'hF; wd[0] = 32'h0;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        #1;
        chk("midreset_resp", {31'h0, resp[0]}, 32'h0);
        @(negedge clk);
        wr[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        exp_oob[0] = 1'b0;
        exp_conf[0] = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (resp[0]) cnt++;
        end
        chk("midreset_no_resp", cnt, 0);
        chk("midreset_conflict_cleared", {31'h0, conf[0]}, 32'h0);
        access(0, 1'b0, 1'b1, 32'h40, 4'h0, 32'h0, 1'b0, got_rd, mexp, known);
        chk("midreset_old_data", got_rd, 32'hDE22_BE44);

        // Held read at LATENCY=1: pulses on every other cycle.
        @(negedge clk);
        rd[1] = 1'b1; addr[1] = 32'h1000;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b_resp_%0d", k), {31'h0, resp[1]}, {31'h0, k[0]});
            if (k[0]) chk($sformatf("b2b_rdata_%0d", k), rdata[1], 32'hCAFE_F00D);
        end
        rd[1] = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    begin w = 1'b0; r = 1'b1; end
                2:       begin w = 1'b1; r = 1'b0; end
                default: begin w = 1'b1; r = 1'b1; end
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'(4 * $urandom_range(0, 100)) + 32'($urandom_range(0, 3));
            else a = 32'h200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            access(0, w, r, a, 4'($urandom), $urandom, 1'b1, got_rd, mexp, known);
            if (known) chk($sformatf("rand%0d_rdata", i), got_rd, mexp);
        end
        chk("final_oob_d0", {31'h0, oob[0]}, {31'h0, exp_oob[0]});
        chk("final_conflict_d0", {31'h0, conf[0]}, {31'h0, exp_conf[0]});
        chk("final_oob_d1", {31'h0, oob[1]}, {31'h0, exp_oob[1]});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/dmem_sram_responder.md
# dmem_sram_responder

Memory-side responder for the CPU's data-memory port. It accepts `dmem_read`/`dmem_write` requests, services them from an internal word-organised SRAM after a fixed, parameterised latency, and returns a single-cycle `dmem_resp`. It is the target end of the CPU↔D-cache interface. Benches and scratchpad configurations use it as a stand-in for the D-cache, with deterministic, configurable response timing.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word-index bits. Capacity is 2^ADDR_WIDTH 32-bit words (4 KiB by default).
- `LATENCY`, 2: cycles from request acceptance to `dmem_resp`. Legal range is 1..15; elaboration fails outside this range.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0. Must be 4-byte aligned.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous reset, active-low (asserted when 0).
- `dmem_read`  in  1: read request, held by the initiator until `dmem_resp`.
- `dmem_write`  in  1: write request, held until `dmem_resp`.
- `dmem_byte_enable`  in  4: write lane mask; bit i enables byte i (`wdata[8i+7:8i]`).
- `dmem_address`  in  32: byte address; bits [1:0] are ignored.
- `dmem_wdata`  in  32: write data.
- `dmem_resp`  out  1: one-cycle completion pulse.
- `dmem_rdata`  out  32: read data, valid when `dmem_resp`=1.
- `oob_flag`  out  1: sticky flag; set on an out-of-range access.
- `conflict_flag`  out  1: sticky flag; set when `dmem_read` and `dmem_write` are both asserted.

## Operation
States are IDLE, WAIT and RESP.

- **IDLE**
  - If `dmem_read` or `dmem_write` is 1, the responder latches the request: op, word index, byte enables and wdata.
  - It loads the counter with LATENCY-1 and moves to WAIT. If LATENCY=1, it moves directly to RESP instead.
  - Otherwise it stays in IDLE.
- **WAIT**
  - The counter decrements each cycle. When the counter is 0, the state moves to RESP.
  - Input changes during WAIT are ignored; the latched request is authoritative.
  - If the initiator drops its request early, the latched access still completes and `dmem_resp` still fires.
- **RESP**
  - Asserts `dmem_resp` for exactly one cycle and performs the access.
  - **Read:** `dmem_rdata` = mem[idx].
  - **Write:** mem[idx] lanes with byte_enable=1 get the matching wdata bytes; `dmem_rdata` = 32'h0.
  - The next state is always IDLE. A request still asserted in the RESP cycle is the held request being completed, so it is not re-accepted.
- **Address decode:** offset = address − BASE_ADDR, computed in 32-bit unsigned arithmetic.
  - In range means offset < 4·2^ADDR_WIDTH; then idx = offset[ADDR_WIDTH+1:2].
  - An out-of-range read returns 32'h0. An out-of-range write leaves memory unmodified.
  - Both cases set `oob_flag` and still respond normally; the responder never hangs.
- **Read and write both asserted at acceptance:** the write wins and `conflict_flag` is set.
- **Byte enable 4'b0000 on a write:** a legal no-op write that still responds.
- **Memory:** contents are not reset and are undefined until written.
- **Sticky flags:** cleared only by reset.

## Timing
- **Reset values:** state=IDLE, counter=0, `dmem_resp`=0, `dmem_rdata`=32'h0, `oob_flag`=0, `conflict_flag`=0.
- **Reset mid-operation:** any pending request is dropped immediately and no response is issued. Memory is untouched, including any write that had not yet reached RESP.
- **Latency:** a request first seen in IDLE at cycle t gives `dmem_resp`=1 during cycle t+LATENCY.
- **Throughput:**
  - IDLE is re-entered at t+LATENCY+1.
  - A back-to-back request is accepted there.
  - The next response comes at t+2·LATENCY+1, so sustained throughput is one access per LATENCY+1 cycles.
- **Data hold:** `dmem_rdata` is registered and holds its last value until the next RESP.
- **Read-after-write:** a write in RESP at cycle c is visible to any read whose RESP is after c.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset defaults:** LATENCY=2; rst=0 then release → `dmem_resp`=0, `dmem_rdata`=0, both flags 0; no response while requests stay idle for 10 cycles.
- **Write then read:** write 32'hDEADBEEF to 0x40 with be=4'hF at t → `dmem_resp` at t+2 only. Then read 0x40 → `dmem_rdata`=32'hDEADBEEF exactly 2 cycles after acceptance.
- **Byte lanes:** write be=4'b0101, wdata=32'h11223344 over 32'hDEADBEEF → read returns 32'hDE22BE44. Address 0x42 (low bits set) hits the same word.
- **Back-to-back:** LATENCY=1; hold `dmem_read` continuously for 3 requests → resp pulses at t+1, t+3 and t+5, each exactly one cycle wide.
- **Out-of-range:** BASE_ADDR=32'h1000, read 0x0FFC and 0x1000+4·2^ADDR_WIDTH → rdata=0, resp returned, `oob_flag`=1 and stays 1. A write to the same addresses leaves memory unchanged.
- **Conflict and mid-op reset:**
  - Read and write asserted together → the write is performed and `conflict_flag`=1.
  - Assert rst during WAIT of a write → no resp, state IDLE, and a later read of that word returns the old data.
